// File: rtl/kgp_rf_trace.sv
// Register-file write tracer: captures watched register writes with a cycle timestamp
// into a first-word-fall-through FIFO. Define KGP_TRACE_DEDUP_EN to suppress repeated writes.
module kgp_rf_trace #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [(2**ADDR_W)-1:0]   watch_mask,
   input  logic                     clr,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [TS_W-1:0]          rd_ts,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              ovf_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic [TS_W-1:0] ts;
   logic [15:0]     ovf_q;

   logic qualify;
   logic dup;
   logic push_req;
   logic pop;
   logic full;
   logic push;
   logic overflow;
   entry_t head;

   assign qualify  = wr_en && watch_mask[wr_addr];
   assign push_req = qualify && !dup && !clr;
   assign pop      = rd_valid && rd_ready && !clr;
   assign full     = (count_q == CW'(DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = push_req && (!full || pop);
   assign overflow = push_req && full && !pop;

`ifdef KGP_TRACE_DEDUP_EN
   logic              last_vld;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_data;

   assign dup = last_vld && (last_addr == wr_addr) && (last_data == wr_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_vld  <= 1'b0;
         last_addr <= '0;
         last_data <= '0;
      end else if (clr) begin
         last_vld  <= 1'b0;
      end else if (push) begin
         last_vld  <= 1'b1;
         last_addr <= wr_addr;
         last_data <= wr_data;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ts      <= '0;
         ovf_q   <= '0;
      end else if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ts      <= '0;
         ovf_q   <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
         if (overflow && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
      end
   end

   // NOTE: storage has no reset; rd_valid masks stale contents and this keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{addr: wr_addr, data: wr_data, ts: ts};
   end

   assign head     = mem[rd_ptr];
   assign rd_addr  = head.addr;
   assign rd_data  = head.data;
   assign rd_ts    = head.ts;
   assign rd_valid = (count_q != '0);
   assign count    = count_q;
   assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_kgp_rf_trace.sv
// Self-checking bench for kgp_rf_trace (DEPTH=4): vector table plus hand-written
// sequences for clear, async reset, dedup, back-pressure and overflow saturation.
module tb_kgp_rf_trace;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] watch_mask;
   logic        clr;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [15:0] rd_ts;
   logic [2:0]  count;
   logic [15:0] ovf_cnt;

   int errors = 0;
   int checks = 0;

   kgp_rf_trace #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .TS_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .watch_mask(watch_mask), .clr(clr), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_ts(rd_ts), .count(count), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        rdy;
      logic [2:0]  e_cnt;
      logic        chk_head;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [15:0] e_ts;
      logic [15:0] e_ovf;
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mkv(logic we, logic [4:0] a, logic [31:0] d, logic rdy,
                                logic [2:0] cnt, logic chk, logic [4:0] ea,
                                logic [31:0] ed, logic [15:0] ets, logic [15:0] eovf);
      vec_t v;
      v.we = we; v.addr = a; v.data = d; v.rdy = rdy; v.e_cnt = cnt;
      v.chk_head = chk; v.e_addr = ea; v.e_data = ed; v.e_ts = ets; v.e_ovf = eovf;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 ns after the rising edge.
   task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic rdy, input logic c);
      wr_en = we; wr_addr = a; wr_data = d; rd_ready = rdy; clr = c;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   initial begin
      exp_t q[$];
      exp_t e;
      int   sent;
      logic rdy;
      logic stalled;
      logic [52:0] prev_head;
      logic done;

      // Stimulus table: idle to ts=4, capture test, overflow, full pop+push, drain.
      for (int i = 0; i < 4; i++) vecs[i] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[4]  = mkv(1, 1, 5,            0, 1, 1, 1, 5,            4,  0);
      vecs[5]  = mkv(1, 3, 9,            0, 1, 1, 1, 5,            4,  0);
      vecs[6]  = mkv(1, 2, 32'hFFFFFFF9, 0, 2, 1, 1, 5,            4,  0);
      vecs[7]  = mkv(0, 0, 0,            1, 1, 1, 2, 32'hFFFFFFF9, 6,  0);
      vecs[8]  = mkv(0, 0, 0,            1, 0, 0, 0, 0,            0,  0);
      vecs[9]  = mkv(1, 1, 10,           0, 1, 1, 1, 10,           9,  0);
      vecs[10] = mkv(1, 2, 11,           0, 2, 1, 1, 10,           9,  0);
      vecs[11] = mkv(1, 1, 12,           0, 3, 1, 1, 10,           9,  0);
      vecs[12] = mkv(1, 2, 13,           0, 4, 1, 1, 10,           9,  0);
      vecs[13] = mkv(1, 1, 14,           0, 4, 1, 1, 10,           9,  1);
      vecs[14] = mkv(1, 2, 15,           0, 4, 1, 1, 10,           9,  2);
      vecs[15] = mkv(1, 1, 16,           1, 4, 1, 2, 11,           10, 2);
      vecs[16] = mkv(0, 0, 0,            1, 3, 1, 1, 12,           11, 2);
      vecs[17] = mkv(0, 0, 0,            1, 2, 1, 2, 13,           12, 2);
      vecs[18] = mkv(0, 0, 0,            1, 1, 1, 1, 16,           15, 2);
      vecs[19] = mkv(0, 0, 0,            1, 0, 0, 0, 0,            0,  2);

      rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; clr = 0; rd_ready = 0;
      watch_mask = 32'h0000_0006;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", rd_valid, 0);
      check("rst_count", count, 0);
      check("rst_ovf", ovf_cnt, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy, 1'b0);
         check($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
         check($sformatf("v%0d_valid", i), rd_valid, vecs[i].e_cnt != 0);
         check($sformatf("v%0d_ovf", i), ovf_cnt, vecs[i].e_ovf);
         if (vecs[i].chk_head) begin
            check($sformatf("v%0d_addr", i), rd_addr, vecs[i].e_addr);
            check($sformatf("v%0d_data", i), rd_data, vecs[i].e_data);
            check($sformatf("v%0d_ts", i), rd_ts, vecs[i].e_ts);
         end
      end

      // clr together with an event, three entries queued and ovf_cnt=2.
      step(1, 1, 20, 0, 0);
      step(1, 2, 21, 0, 0);
      step(1, 1, 22, 0, 0);
      check("pre_clr_count", count, 3);
      check("pre_clr_ovf", ovf_cnt, 2);
      step(1, 2, 23, 0, 1);
      check("clr_count", count, 0);
      check("clr_valid", rd_valid, 0);
      check("clr_ovf", ovf_cnt, 0);
      step(0, 0, 0, 0, 0);
      step(1, 1, 30, 0, 0);
      check("post_clr_count", count, 1);
      check("post_clr_addr", rd_addr, 1);
      check("post_clr_data", rd_data, 30);
      check("post_clr_ts", rd_ts, 1);

      // Asynchronous reset mid-cycle clears outputs before the next edge.
      step(1, 2, 31, 0, 0);
      check("pre_rst_count", count, 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", rd_valid, 0);
      check("arst_count", count, 0);
      wr_en = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1, 1, 40, 0, 0);
      check("post_rst_count", count, 1);
      check("post_rst_ts", rd_ts, 0);
      check("post_rst_data", rd_data, 40);
      step(0, 0, 0, 1, 0);
      check("post_rst_drain", count, 0);

      // Dedup: three identical writes to r4.
      watch_mask = 32'hFFFF_FFFF;
      step(1, 4, 7, 0, 0);
      step(1, 4, 7, 0, 0);
      step(1, 4, 7, 0, 0);
`ifdef KGP_TRACE_DEDUP_EN
      check("dedup_count", count, 1);
`else
      check("dedup_count", count, 3);
`endif
      check("dedup_ovf", ovf_cnt, 0);
      check("dedup_head", {rd_addr, rd_data}, {5'd4, 32'd7});
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      check("dedup_drain", count, 0);

      // Back-pressure: random rd_ready over 50 events against a scoreboard queue.
      sent = 0;
      stalled = 1'b0;
      prev_head = '0;
      done = 1'b0;
      for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
         check("bp_count", count, q.size());
         if (stalled) check("bp_stable", {rd_addr, rd_data, rd_ts}, prev_head);
         rdy = 1'($urandom_range(1, 0));
         if (rd_valid && rdy && q.size() != 0) begin
            e = q.pop_front();
            check("bp_head", {rd_addr, rd_data}, {e.addr, e.data});
         end
         stalled = rd_valid && !rdy;
         prev_head = {rd_addr, rd_data, rd_ts};
         if (sent < 50 && q.size() < 4) begin
            e.addr = 5'($urandom_range(31, 0));
            e.data = 32'h1000 + 32'(sent);
            q.push_back(e);
            sent++;
            step(1, e.addr, e.data, rdy, 0);
         end else begin
            step(0, 0, 0, rdy, 0);
         end
         done = (sent == 50) && (q.size() == 0) && !rd_valid;
      end
      check("bp_done", done, 1);
      check("bp_ovf", ovf_cnt, 0);

      // Overflow counter saturation.
      for (int i = 0; i < 65544; i++) step(1, 0, 32'h2_0000 + 32'(i), 0, 0);
      check("sat_count", count, 4);
      check("sat_ovf", ovf_cnt, 16'hFFFF);
      check("sat_head", rd_data, 32'h2_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
